// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator sequencer: opcodes, flag bits,
// instruction field offsets and FSM state encoding.
package cpu_pkg;

    // Major opcodes, IR[23:20]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALUI = 4'h1;
    localparam logic [3:0] OP_ALUM = 4'h2;
    localparam logic [3:0] OP_STA  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JZ   = 4'h5;
    localparam logic [3:0] OP_JNZ  = 4'h6;
    localparam logic [3:0] OP_JC   = 4'h7;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Flag-register bit positions
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;

    // Opcode fields sit directly above the DATA_W-bit operand; offsets are
    // relative to DATA_W so the format scales with the operand width.
    localparam int unsigned OPC_W      = 4;
    localparam int unsigned IR_ALU_OFS = 0;
    localparam int unsigned IR_MAJ_OFS = 4;

    // Sequencer states
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_MEM    = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    // Jump condition classes produced by the decoder
    typedef enum logic [2:0] {
        JcNone,
        JcAlways,
        JcZero,
        JcNotZero,
        JcCarry
    } jump_cond_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational major-opcode decoder: classifies the latched instruction.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0] major_op,
    output logic       is_alu,
    output logic       uses_mem,
    output logic       is_store,
    output logic [2:0] jump_cond,
    output logic       is_halt
);

    // Opcodes 8..14 and NOP fall through to the all-inactive default.
    always_comb begin
        is_alu    = 1'b0;
        uses_mem  = 1'b0;
        is_store  = 1'b0;
        jump_cond = JcNone;
        is_halt   = 1'b0;
        case (major_op)
            OP_ALUI: is_alu = 1'b1;
            OP_ALUM: begin
                is_alu   = 1'b1;
                uses_mem = 1'b1;
            end
            OP_STA:  is_store  = 1'b1;
            OP_JMP:  jump_cond = JcAlways;
            OP_JZ:   jump_cond = JcZero;
            OP_JNZ:  jump_cond = JcNotZero;
            OP_JC:   jump_cond = JcCarry;
            OP_HLT:  is_halt   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_control_unit.sv
// Fetch/decode/execute sequencer for the accumulator datapath. Owns PC, IR
// and the FSM; drives ALU opcode/operand, datapath strobes and data memory.
module acc_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned DADDR_W = 8,
    parameter int unsigned FLAG_W  = 5
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    output logic [PC_W-1:0]     PROG_ADDR,
    input  logic [DATA_W+7:0]   PROG_DATA,
    output logic [DADDR_W-1:0]  DMEM_ADDR,
    input  logic [DATA_W-1:0]   DMEM_RDATA,
    output logic [DATA_W-1:0]   DMEM_WDATA,
    output logic                DMEM_WE,
    input  logic [DATA_W-1:0]   A_IN,
    input  logic [FLAG_W-1:0]   FLAGS,
    output logic [3:0]          ALU_OP,
    output logic [DATA_W-1:0]   ARG2,
    output logic                A_CE,
    output logic                FLAG_CE,
    output logic                HALTED
);

    localparam int unsigned IR_W = DATA_W + 8;

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;

    logic [3:0] major_op;
    logic [3:0] fetched_op;
    logic       is_alu, uses_mem, is_store, is_halt;
    logic [2:0] jump_cond;
    logic       jump_taken;
    logic       exec_active;

    // Only C and Z are consumed; remaining flag bits are intentionally ignored.
    logic unused_flags;
    assign unused_flags = ^FLAGS;

    assign major_op   = ir_q[DATA_W+IR_MAJ_OFS +: OPC_W];
    assign fetched_op = PROG_DATA[DATA_W+IR_MAJ_OFS +: OPC_W];

    instr_decode u_decode (
        .major_op  (major_op),
        .is_alu    (is_alu),
        .uses_mem  (uses_mem),
        .is_store  (is_store),
        .jump_cond (jump_cond),
        .is_halt   (is_halt)
    );

    // Evaluate the branch condition against the registered flags.
    always_comb begin
        jump_taken = 1'b0;
        case (jump_cond)
            JcAlways:  jump_taken = 1'b1;
            JcZero:    jump_taken = FLAGS[FLAG_Z];
            JcNotZero: jump_taken = ~FLAGS[FLAG_Z];
            JcCarry:   jump_taken = FLAGS[FLAG_C];
            default:   jump_taken = 1'b0;
        endcase
    end

    // Next-state logic; EN low (or HALT) holds state, PC and IR.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (EN && state_q != ST_HALT) begin
            case (state_q)
                ST_FETCH:  state_d = ST_DECODE;
                ST_DECODE: begin
                    ir_d    = PROG_DATA;
                    pc_d    = pc_q + 1'b1;
                    state_d = (fetched_op == OP_ALUM) ? ST_MEM : ST_EXEC;
                end
                ST_MEM:    state_d = ST_EXEC;
                ST_EXEC: begin
                    if (jump_taken) pc_d = ir_q[PC_W-1:0];
                    state_d = is_halt ? ST_HALT : ST_FETCH;
                end
                default:   state_d = ST_FETCH;
            endcase
        end
    end

    // Sequencer registers; reset discards any in-flight instruction.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs; strobes are gated by EN so a stall mid-EXEC suppresses them.
    always_comb begin
        exec_active = EN && (state_q == ST_EXEC);
        A_CE        = exec_active && is_alu;
        FLAG_CE     = exec_active && is_alu;
        DMEM_WE     = exec_active && is_store;
        ARG2        = (state_q == ST_EXEC && uses_mem) ? DMEM_RDATA : ir_q[DATA_W-1:0];
        ALU_OP      = ir_q[DATA_W+IR_ALU_OFS +: OPC_W];
        DMEM_ADDR   = ir_q[DADDR_W-1:0];
        DMEM_WDATA  = A_IN;
        PROG_ADDR   = pc_q;
        HALTED      = (state_q == ST_HALT);
    end

endmodule

// File: tb/tb_acc_control_unit.sv
// Directed bench for acc_control_unit with a behavioural ROM and data memory.
module tb_acc_control_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  prog_addr;
    logic [23:0] prog_data;
    logic [7:0]  dmem_addr;
    logic [15:0] dmem_rdata;
    logic [15:0] dmem_wdata;
    logic        dmem_we;
    logic [15:0] a_in;
    logic [4:0]  flags;
    logic [3:0]  alu_op;
    logic [15:0] arg2;
    logic        a_ce;
    logic        flag_ce;
    logic        halted;

    logic [23:0] rom  [256];
    logic [15:0] dmem [256];

    int checks;
    int failures;

    acc_control_unit dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .EN         (en),
        .PROG_ADDR  (prog_addr),
        .PROG_DATA  (prog_data),
        .DMEM_ADDR  (dmem_addr),
        .DMEM_RDATA (dmem_rdata),
        .DMEM_WDATA (dmem_wdata),
        .DMEM_WE    (dmem_we),
        .A_IN       (a_in),
        .FLAGS      (flags),
        .ALU_OP     (alu_op),
        .ARG2       (arg2),
        .A_CE       (a_ce),
        .FLAG_CE    (flag_ce),
        .HALTED     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM and data memory: one-cycle read latency.
    always @(posedge clk) begin
        prog_data  <= rom[prog_addr];
        dmem_rdata <= dmem[dmem_addr];
        if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) begin
            rom[i]  = 24'h000000;
            dmem[i] = 16'h0000;
        end
        rom[8'h00] = 24'h104E20; // ALUI add 20000
        rom[8'h01] = 24'h210005; // ALUM sub [5]
        rom[8'h02] = 24'h300010; // STA 0x10
        rom[8'h03] = 24'h500040; // JZ 0x40
        rom[8'h04] = 24'hF00000; // HLT
        rom[8'h40] = 24'h500050; // JZ 0x50
        rom[8'h41] = 24'h70007F; // JC 0x7F
        rom[8'h7F] = 24'h4000FF; // JMP 0xFF
        rom[8'hFF] = 24'h000000; // NOP, PC wraps to 0
        dmem[5]    = 16'd7;

        rst_n = 1'b0;
        en    = 1'b1;
        flags = 5'b00000;
        a_in  = 16'h0000;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_prog_addr", 32'(prog_addr), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_arg2", 32'(arg2), 32'h0);
        check("rst_alu_op", 32'(alu_op), 32'h0);

        // Reset asserted during ALUI EXEC drops strobes immediately
        ticks(2);
        check("pre_rst_a_ce", 32'(a_ce), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_ce", 32'(a_ce), 32'h0);
        check("mid_rst_flag_ce", 32'(flag_ce), 32'h0);
        check("mid_rst_prog_addr", 32'(prog_addr), 32'h0);
        check("mid_rst_halted", 32'(halted), 32'h0);
        check("mid_rst_arg2", 32'(arg2), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // ALUI: strobes only in cycle 3
        check("alui_c1_a_ce", 32'(a_ce), 32'h0);
        tick();
        check("alui_c2_a_ce", 32'(a_ce), 32'h0);
        tick();
        check("alui_c3_a_ce", 32'(a_ce), 32'h1);
        check("alui_c3_flag_ce", 32'(flag_ce), 32'h1);
        check("alui_alu_op", 32'(alu_op), 32'h0);
        check("alui_arg2", 32'(arg2), 32'd20000);
        check("alui_dmem_we", 32'(dmem_we), 32'h0);
        tick();
        check("alui_next_pc", 32'(prog_addr), 32'h1);
        check("alui_c4_a_ce", 32'(a_ce), 32'h0);

        // ALUM: EXEC in cycle 4 with memory operand
        tick();
        tick();
        check("alum_mem_addr", 32'(dmem_addr), 32'h5);
        check("alum_mem_a_ce", 32'(a_ce), 32'h0);
        check("alum_mem_arg2", 32'(arg2), 32'h5);
        tick();
        check("alum_exec_arg2", 32'(arg2), 32'd7);
        check("alum_exec_op", 32'(alu_op), 32'h1);
        check("alum_exec_a_ce", 32'(a_ce), 32'h1);
        tick();
        check("alum_next_pc", 32'(prog_addr), 32'h2);
        check("alum_after_a_ce", 32'(a_ce), 32'h0);

        // STA
        a_in = 16'h1234;
        ticks(2);
        check("sta_we", 32'(dmem_we), 32'h1);
        check("sta_addr", 32'(dmem_addr), 32'h10);
        check("sta_wdata", 32'(dmem_wdata), 32'h1234);
        check("sta_a_ce", 32'(a_ce), 32'h0);
        check("sta_flag_ce", 32'(flag_ce), 32'h0);
        tick();
        check("sta_we_off", 32'(dmem_we), 32'h0);
        check("sta_next_pc", 32'(prog_addr), 32'h3);

        // Conditional and unconditional jumps
        flags = 5'b00010;
        ticks(3);
        check("jz_taken", 32'(prog_addr), 32'h40);
        flags = 5'b00000;
        ticks(3);
        check("jz_not_taken", 32'(prog_addr), 32'h41);
        flags = 5'b00001;
        ticks(3);
        check("jc_taken", 32'(prog_addr), 32'h7F);
        ticks(3);
        check("jmp_ff", 32'(prog_addr), 32'hFF);
        ticks(3);
        check("pc_wrap", 32'(prog_addr), 32'h0);

        // Second pass: stall inside ALUI EXEC suppresses strobes
        ticks(2);
        check("p2_alui_a_ce", 32'(a_ce), 32'h1);
        en = 1'b0;
        #1;
        check("exec_stall_a_ce", 32'(a_ce), 32'h0);
        check("exec_stall_flag_ce", 32'(flag_ce), 32'h0);
        tick();
        check("exec_stall_hold_a_ce", 32'(a_ce), 32'h0);
        check("exec_stall_pc", 32'(prog_addr), 32'h1);
        en = 1'b1;
        #1;
        check("exec_resume_a_ce", 32'(a_ce), 32'h1);
        tick();
        check("p2_alui_next_pc", 32'(prog_addr), 32'h1);

        // ALUM with EN low for 5 cycles in MEM: EXEC moves from cycle 4 to 9
        ticks(2);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("alum_stall_a_ce", 32'(a_ce), 32'h0);
            check("alum_stall_flag_ce", 32'(flag_ce), 32'h0);
        end
        en = 1'b1;
        #1;
        check("alum_stall_c8_a_ce", 32'(a_ce), 32'h0);
        tick();
        check("alum_late_a_ce", 32'(a_ce), 32'h1);
        check("alum_late_arg2", 32'(arg2), 32'd7);
        tick();
        check("alum_late_next_pc", 32'(prog_addr), 32'h2);

        // STA then JZ not taken, then HLT
        ticks(3);
        check("p2_sta_next_pc", 32'(prog_addr), 32'h3);
        flags = 5'b00000;
        ticks(3);
        check("p2_jz_not_taken", 32'(prog_addr), 32'h4);
        ticks(2);
        check("hlt_exec_halted", 32'(halted), 32'h0);
        tick();
        check("hlt_halted", 32'(halted), 32'h1);
        check("hlt_pc", 32'(prog_addr), 32'h5);
        for (int i = 0; i < 20; i++) begin
            en = i[0];
            tick();
            check("halt_pc_frozen", 32'(prog_addr), 32'h5);
            check("halt_strobes", 32'({a_ce, flag_ce, dmem_we}), 32'h0);
            check("halt_stays", 32'(halted), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
